rr_grant_index: RTL and testbench

- Round-robin arbiter that sits directly upstream of the decoder.
- Takes N request lines and selects one requester fairly.
- Presents the winner as a binary index `a` with a valid/enable `en`; these drive the decoder's `a`/`en` inputs to form the one-hot grant vector.
- Holds each grant until it is acknowledged or a hold-limit timeout expires.

---
 rtl/rr_grant_index_pkg.sv | 8 +
 rtl/rr_pick.sv | 25 ++
 rtl/rr_grant_index.sv | 67 ++++++
 tb/tb_rr_grant_index.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rr_grant_index_pkg.sv
// rr_grant_index_pkg: shared state encoding and counter sizing for the round-robin grant block
package rr_grant_index_pkg;
  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  function automatic int cnt_w(input int max_hold);
    return ($clog2(max_hold + 1) > 1) ? $clog2(max_hold + 1) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, ascending with wrap
module rr_pick #(
  parameter int IP_WIDTH = 4
) (
  input  logic [(1<<IP_WIDTH)-1:0] req,
  input  logic [IP_WIDTH-1:0]      ptr,
  output logic                     found,
  output logic [IP_WIDTH-1:0]      idx
);
  localparam int N = 1 << IP_WIDTH;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  // Descending scan so the lowest rotated position (closest to ptr) wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) begin
        found = 1'b1;
        idx   = ptr + IP_WIDTH'(i);
      end
  end
endmodule

// File: rtl/rr_grant_index.sv
// rr_grant_index: round-robin arbiter presenting a held grant as index a with valid en
module rr_grant_index
  import rr_grant_index_pkg::*;
#(
  parameter int IP_WIDTH = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [(1<<IP_WIDTH)-1:0] req,
  input  logic                     ack,
  output logic                     en,
  output logic [IP_WIDTH-1:0]      a,
  output logic                     timeout
);
  localparam int CW = cnt_w(MAX_HOLD);
  localparam logic [CW-1:0] LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
  logic                st;
  logic [IP_WIDTH-1:0] ptr;
  logic [IP_WIDTH-1:0] pick_ptr;
  logic [CW-1:0]       cnt;
  logic                found;
  logic [IP_WIDTH-1:0] idx;
  logic                expire;
  logic                rel;
  // On release the just-served index drops to lowest priority in the same edge
  assign pick_ptr = (st == GRANT) ? a + IP_WIDTH'(1) : ptr;
  assign expire   = (MAX_HOLD > 0) && (cnt == LAST) && !ack;
  assign rel      = ack || expire;
  rr_pick #(.IP_WIDTH(IP_WIDTH)) u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .found(found),
    .idx  (idx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      en      <= 1'b0;
      a       <= '0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      if (st == IDLE) begin
        if (found) begin
          a   <= idx;
          en  <= 1'b1;
          cnt <= '0;
          st  <= GRANT;
        end
      end else if (rel) begin
        ptr     <= pick_ptr;
        timeout <= expire;
        cnt     <= '0;
        if (found) a <= idx;
        else begin
          en <= 1'b0;
          st <= IDLE;
        end
      end else begin
        cnt <= (MAX_HOLD > 0) ? cnt + CW'(1) : cnt;
      end
    end
  end
endmodule

// File: tb/tb_rr_grant_index.sv
// tb_rr_grant_index: checks MAX_HOLD=8 and MAX_HOLD=0 arbiters against a reference model
module tb_rr_grant_index;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       ack = 1'b0;
  logic       en_v [2];
  logic [1:0] a_v  [2];
  logic       to_v [2];
  int n_chk  = 0;
  int n_fail = 0;
  int mh   [2] = '{8, 0};
  int m_ptr[2], m_a[2], m_cnt[2];
  bit m_en [2], m_to[2];

  always #5 clk = ~clk;

  rr_grant_index #(.IP_WIDTH(2), .MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .en(en_v[0]), .a(a_v[0]), .timeout(to_v[0])
  );
  rr_grant_index #(.IP_WIDTH(2), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .en(en_v[1]), .a(a_v[1]), .timeout(to_v[1])
  );

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_a[i] = 0; m_cnt[i] = 0; m_en[i] = 0; m_to[i] = 0;
    end
  endtask

  // m_cnt = cycles already held beyond the first; forced release after mh cycles of holding
  task automatic model_step();
    int w;
    bit forced;
    for (int i = 0; i < 2; i++) begin
      m_to[i] = 0;
      if (!m_en[i]) begin
        w = pick(m_ptr[i], req);
        if (w >= 0) begin m_en[i] = 1; m_a[i] = w; m_cnt[i] = 0; end
      end else begin
        forced = !ack && mh[i] > 0 && (m_cnt[i] + 1 == mh[i]);
        if (ack || forced) begin
          m_ptr[i] = (m_a[i] + 1) % 4;
          m_to[i]  = forced;
          w = pick(m_ptr[i], req);
          if (w >= 0) begin m_a[i] = w; m_cnt[i] = 0; end
          else m_en[i] = 0;
        end else m_cnt[i]++;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/en8"}, int'(en_v[0]), int'(m_en[0]));
    chk({tag, "/a8"},  int'(a_v[0]),  m_a[0]);
    chk({tag, "/to8"}, int'(to_v[0]), int'(m_to[0]));
    chk({tag, "/en0"}, int'(en_v[1]), int'(m_en[1]));
    chk({tag, "/a0"},  int'(a_v[1]),  m_a[1]);
    chk({tag, "/to0"}, int'(to_v[1]), int'(m_to[1]));
  endtask

  task automatic cyc(input string tag, input logic [3:0] r, input logic k);
    req = r;
    ack = k;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Asserted mid-cycle so the async path must clear outputs before the next edge
  task automatic mid_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "/async"});
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("por");
    @(posedge clk);
    #1 rst = 1'b0;
    // single request, hold, ack with nothing pending, then ptr=3 priority
    cyc("single", 4'b0100, 1'b0);
    chk("single_a", int'(a_v[0]), 2);
    for (int i = 0; i < 3; i++) cyc("hold", 4'b0100, 1'b0);
    cyc("ack_idle", 4'b0000, 1'b1);
    chk("ack_idle_en", int'(en_v[0]), 0);
    cyc("ptr3", 4'b1111, 1'b0);
    chk("ptr3_a", int'(a_v[0]), 3);
    // async reset while granted, then ptr back at 0
    mid_reset("rst1");
    cyc("after_rst", 4'b0001, 1'b0);
    chk("after_rst_a", int'(a_v[0]), 0);
    cyc("rel", 4'b0000, 1'b1);
    // fair rotation with continuous ack
    for (int i = 0; i < 7; i++) cyc("rot", 4'b1111, 1'b1);
    // wrap and priority: steer to a=2 then ack with 0011
    mid_reset("rst2");
    cyc("g2", 4'b0100, 1'b0);
    cyc("wrap", 4'b0011, 1'b1);
    chk("wrap_a", int'(a_v[0]), 0);
    cyc("wrap2", 4'b0011, 1'b1);
    chk("wrap2_a", int'(a_v[0]), 1);
    // timeout on dut8, indefinite hold on dut0
    mid_reset("rst3");
    for (int i = 0; i < 110; i++) cyc("hold_to", 4'b0011, 1'b0);
    chk("nohold_a0", int'(a_v[1]), 0);
    // ack on the expiry cycle, and granted req dropped mid-grant
    mid_reset("rst4");
    for (int i = 0; i < 8; i++) cyc("pre_col", 4'b0011, 1'b0);
    cyc("collide", 4'b0011, 1'b1);
    cyc("collide_next", 4'b0011, 1'b0);
    for (int i = 0; i < 3; i++) cyc("drop", 4'b0000, 1'b0);
    cyc("drop_ack", 4'b1000, 1'b1);
    // random traffic with occasional async reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
      cyc("rnd", 4'($urandom), ($urandom_range(0, 3) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
